// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display peripheral
// and for other users of the hex segment decode.
package seg7_pkg;

  localparam logic [1:0] SEG7_DATA = 2'd0;
  localparam logic [1:0] SEG7_CTRL = 2'd1;
  localparam logic [1:0] SEG7_STAT = 2'd2;

  localparam logic [31:0] SEG7_CTRL_RST = 32'h0000_00FF;

  localparam logic [7:0] SEG7_BLANK = 8'hFF;

  // Active-low gfedcba codes; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG7_CODES = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic       blank;
    logic [7:0] dpmask;
    logic [7:0] enable;
  } seg7_ctrl_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low gfedcba segment decode.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG7_CODES[hex];
  end

endmodule

// File: rtl/seg7_bus_slave.sv
// Memory-mapped 8-digit common-anode 7-segment display peripheral with
// DATA/CTRL/STATUS registers and a prescaled digit scan.
module seg7_bus_slave
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              rw,
  input  logic [3:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [31:0]       data_q;
  seg7_ctrl_t        ctrl_q;
  logic [PW-1:0]     pre_q;
  logic [IW-1:0]     idx_q;
  logic [31:0]       rd_mux;
  logic [6:0]        hex_seg;
  logic [DIGITS-1:0] an_d;
  logic              unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:17]};

  always_comb begin
    rd_mux = '0;
    case (addr[3:2])
      SEG7_DATA: rd_mux = data_q;
      SEG7_CTRL: rd_mux = {15'b0, ctrl_q};
      SEG7_STAT: rd_mux = 32'(idx_q);
      default:   rd_mux = '0;
    endcase
  end

  // Every selected edge is a complete access; rdata only moves on reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ctrl_q <= seg7_ctrl_t'(SEG7_CTRL_RST[16:0]);
      ack    <= 1'b0;
      rdata  <= '0;
    end else begin
      ack <= sel;
      if (sel && rw) begin
        case (addr[3:2])
          SEG7_DATA: data_q <= wdata;
          SEG7_CTRL: ctrl_q <= seg7_ctrl_t'(wdata[16:0]);
          default:   ;
        endcase
      end
      if (sel && !rw) begin
        rdata <= rd_mux;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_MAX) begin
      pre_q <= '0;
      idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  hex_to_seg7 u_hex (
    .hex (data_q[{idx_q, 2'b00} +: 4]),
    .seg (hex_seg)
  );

  always_comb begin
    an_d = '1;
    if (!ctrl_q.blank && ctrl_q.enable[idx_q]) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG7_BLANK;
    end else begin
      an  <= an_d;
      seg <= {~ctrl_q.dpmask[idx_q], hex_seg};
    end
  end

endmodule
